// File: rtl/servant_wb_initiator.sv
// Queued single-cycle Wishbone initiator for the servant peripheral bus.
// Define WB_TIMEOUT_EN to abort cycles unacknowledged for TO_CYCLES clocks.
module servant_wb_initiator #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_adr,
  input  logic [31:0] i_cmd_dat,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_dat,
  output logic        o_rsp_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } state_e;

  cmd_t        mem_q [CMD_DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        rdy_en_q;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  cmd_t        head;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // Held low through reset; rises on the first clock after release.
  assign o_cmd_ready = rdy_en_q & ~full;
  assign push = i_cmd_valid & o_cmd_ready;
  assign head = mem_q[rptr_q[AW-1:0]];

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          rsp_err_q, rsp_err_d;
`else
  logic unused_to;
  assign unused_to = |TO_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          adr_d   = head.adr;
          dat_d   = head.dat;
          we_d    = head.we;
          cyc_d   = 1'b1;
          state_d = BUS;
`ifdef WB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      BUS: begin
        if (i_wb_ack) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 32'h0 : i_wb_rdt;
          state_d     = RSP;
`ifdef WB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'hDEAD_BEEF;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end else begin
          to_cnt_d    = to_cnt_q + 1'b1;
`endif
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      for (int i = 0; i < int'(CMD_DEPTH); i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rdy_en_q    <= 1'b0;
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rdy_en_q <= 1'b1;
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= '{we: i_cmd_we, adr: i_cmd_adr, dat: i_cmd_dat};
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop) rptr_q <= rptr_q + PTR_ONE;
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef WB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign o_wb_adr    = adr_q;
  assign o_wb_dat    = dat_q;
  assign o_wb_we     = we_q;
  assign o_wb_cyc    = cyc_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_dat   = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
  assign o_rsp_err   = rsp_err_q;
`else
  assign o_rsp_err   = 1'b0;
`endif
  assign o_busy      = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_servant_wb_initiator.sv
// Directed bench for servant_wb_initiator: vector table plus
// back-pressure, back-to-back, reset and timeout sequences.
module tb_servant_wb_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        busy;

  // 0 comb ack, 1 registered ack, 2 never, 3 ack on 8th cyc cycle
  int          mode = 1;
  logic        ack_r = 1'b0;
  int          cyc_run = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  servant_wb_initiator #(.CMD_DEPTH(4), .TO_CYCLES(8)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_we   (cmd_we),
    .i_cmd_adr  (cmd_adr),
    .i_cmd_dat  (cmd_dat),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_dat  (rsp_dat),
    .o_rsp_err  (rsp_err),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .o_busy     (busy)
  );

  assign wb_rdt = wb_adr ^ 32'hA000_000A;
  assign wb_ack = (mode == 0) ? wb_cyc :
                  (mode == 1) ? ack_r :
                  (mode == 3) ? (wb_cyc && cyc_run == 7) : 1'b0;

  always @(posedge clk) begin
    ack_r   <= wb_cyc & ~ack_r;
    cyc_run <= wb_cyc ? cyc_run + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          mode;
    logic [31:0] exp_dat;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int  k, first, ncyc, bad;
    bit  got;
    mode = v.mode;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we = v.we;
    cmd_adr = v.adr;
    cmd_dat = v.dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cyc_not_yet", {31'b0, wb_cyc}, 32'd0);
    first = -1; ncyc = 0; bad = 0; got = 0; k = 1;
    @(negedge clk);
    while (!got && k <= 40) begin
      if (wb_cyc) begin
        if (first < 0) first = k;
        ncyc++;
        if (wb_adr !== v.adr || wb_we !== v.we || wb_dat !== v.dat) bad++;
      end
      if (rsp_valid) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("rsp_seen", {31'b0, got}, 32'd1);
    check("cyc_first", first, 32'd1);
    check("cyc_len", ncyc, v.exp_cyc);
    check("bus_stable", bad, 32'd0);
    check("rsp_dat", rsp_dat, v.exp_dat);
    check("rsp_err", {31'b0, rsp_err}, 32'd0);
    check("busy_rsp", {31'b0, busy}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_clear", {31'b0, rsp_valid}, 32'd0);
    check("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] bp_exp [5];

  initial begin
    vecs[0] = '{1'b1, 32'h4000_0000, 32'h0000_000A, 1, 32'h0, 2};
    vecs[1] = '{1'b0, 32'h4000_0000, 32'h0, 1, 32'hE000_000A, 2};
    vecs[2] = '{1'b0, 32'h4000_0004, 32'h0, 0, 32'hE000_000E, 1};
    vecs[3] = '{1'b1, 32'h4000_0008, 32'hFFFF_FFFF, 0, 32'h0, 1};
    vecs[4] = '{1'b0, 32'h5000_000A, 32'h0, 1, 32'hF000_0000, 2};
    vecs[5] = '{1'b1, 32'h4000_000C, 32'h1234_5678, 1, 32'h0, 2};
    bp_exp[0] = 32'hE000_000A;
    bp_exp[1] = 32'hE000_000E;
    bp_exp[2] = 32'hE000_0002;
    bp_exp[3] = 32'hE000_0006;
    bp_exp[4] = 32'hE000_001A;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_rspv", {31'b0, rsp_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_rdat", rsp_dat, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, cmd_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // back-pressure: five reads, responses held off
    mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_we = 1'b0;
      cmd_adr = 32'h4000_0000 + 32'(4 * i);
      cmd_dat = 32'h0;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_full", {31'b0, cmd_ready}, 32'd0);
    check("bp_rspv", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      int w;
      w = 0;
      while (!rsp_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("bp_rsp_seen", {31'b0, rsp_valid}, 32'd1);
      check("bp_order", rsp_dat, bp_exp[i]);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    check("bp_busy_end", {31'b0, busy}, 32'd0);

    // zero-wait back-to-back with rsp_ready held high
    mode = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_adr = 32'h4000_0020;
    for (int k = 0; k < 7; k++) begin
      logic [6:0] ec, ev;
      ec = 7'b0010010;
      ev = 7'b0100100;
      @(negedge clk);
      check("b2b_cyc", {31'b0, wb_cyc}, {31'b0, ec[k]});
      check("b2b_rspv", {31'b0, rsp_valid}, {31'b0, ev[k]});
      if (k == 2) check("b2b_dat0", rsp_dat, 32'hE000_002A);
      if (k == 5) check("b2b_dat1", rsp_dat, 32'hE000_002E);
      if (k == 0) cmd_adr = 32'h4000_0024;
      if (k == 1) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;

    // reset in the middle of a cycle with two commands queued
    mode = 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we = 1'b1;
      cmd_adr = 32'h4000_0100 + 32'(i);
      cmd_dat = 32'(i);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_cyc", {31'b0, wb_cyc}, 32'd1);
    check("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("arst_rspv", {31'b0, rsp_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    mode = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rsp_valid || wb_cyc || busy) stale++;
      end
      check("no_stale", stale, 32'd0);
    end
    rsp_ready = 1'b0;

`ifdef WB_TIMEOUT_EN
    for (int t = 0; t < 2; t++) begin
      int n, w;
      mode = (t == 0) ? 2 : 3;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_we = 1'b0;
      cmd_adr = 32'h4000_0200;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0; w = 0;
      while (!rsp_valid && w < 40) begin
        @(negedge clk);
        if (wb_cyc) n++;
        w++;
      end
      check("to_seen", {31'b0, rsp_valid}, 32'd1);
      check("to_len", n, 32'd8);
      check("to_err", {31'b0, rsp_err}, (t == 0) ? 32'd1 : 32'd0);
      check("to_dat", rsp_dat, (t == 0) ? 32'hDEAD_BEEF : 32'hE000_020A);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
